// File: rtl/loop_seq_pkg.sv
// loop_seq_pkg: shared state encoding, width helper and default index/count types for the loop nest sequencer
package loop_seq_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  localparam int N_OUTER_DEF = 8;
  localparam int N_INNER_DEF = 8;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  typedef logic [idx_w(N_OUTER_DEF)-1:0] outer_idx_t;
  typedef logic [idx_w(N_INNER_DEF)-1:0] inner_idx_t;
  typedef logic [$clog2(N_OUTER_DEF+1)-1:0] outer_cnt_t;
  typedef logic [$clog2(N_INNER_DEF+1)-1:0] inner_cnt_t;
endpackage

// File: rtl/loop_nest_counter.sv
// loop_nest_counter: bounded index counter for one loop level
//   clk, rst_n : clock, async active-low reset
//   clr, inc   : clear to 0 (priority), advance by one (wraps to 0 at terminal count)
//   limit      : latched trip count; tc flags cnt == limit-1
//   cnt, tc    : current index, terminal-count flag
module loop_nest_counter #(
  parameter int W  = 3,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  input  logic [CW-1:0] limit,
  output logic [W-1:0]  cnt,
  output logic          tc
);
  logic [W-1:0] cnt_q, cnt_d;
  assign tc  = CW'(cnt_q) == limit - CW'(1);
  assign cnt = cnt_q;
  always_comb cnt_d = clr ? '0 : (inc ? (tc ? '0 : cnt_q + W'(1)) : cnt_q);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
endmodule

// File: rtl/loop_nest_sequencer.sv
// loop_nest_sequencer: issues the (i, j) index stream of a two-level loop nest, i-major, one beat per handshake
//   clk, rst_n            : clock, async active-low reset
//   start, abort          : begin a scan (IDLE only), terminate a running scan
//   cfg_outer, cfg_inner  : trip counts, latched and clamped on an accepted start
//   out_valid/out_ready   : beat handshake; out_i, out_j indices; first/last markers
//   busy, done            : not idle; one-cycle pulse on normal completion
module loop_nest_sequencer
  import loop_seq_pkg::*;
#(
  parameter int N_OUTER = 8,
  parameter int N_INNER = 8,
  parameter int IW      = idx_w(N_OUTER),
  parameter int JW      = idx_w(N_INNER)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         abort,
  input  logic [$clog2(N_OUTER+1)-1:0] cfg_outer,
  input  logic [$clog2(N_INNER+1)-1:0] cfg_inner,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [IW-1:0]                out_i,
  output logic [JW-1:0]                out_j,
  output logic                         out_first_inner,
  output logic                         out_last_inner,
  output logic                         out_last,
  output logic                         busy,
  output logic                         done
);
  localparam int OCW = $clog2(N_OUTER+1);
  localparam int ICW = $clog2(N_INNER+1);
  state_e           state_q, state_d;
  logic [OCW-1:0]   outer_cnt_q, outer_cnt_d, outer_clamp;
  logic [ICW-1:0]   inner_cnt_q, inner_cnt_d, inner_clamp;
  logic             run, beat, clr, inner_tc, outer_tc;
  assign outer_clamp = (cfg_outer > OCW'(N_OUTER)) ? OCW'(N_OUTER) : cfg_outer;
  assign inner_clamp = (cfg_inner > ICW'(N_INNER)) ? ICW'(N_INNER) : cfg_inner;
  assign run  = state_q == RUN;
  assign beat = run && out_ready;
  always_comb begin
    state_d     = state_q;
    outer_cnt_d = outer_cnt_q;
    inner_cnt_d = inner_cnt_q;
    clr         = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        outer_cnt_d = outer_clamp;
        inner_cnt_d = inner_clamp;
        clr         = 1'b1;
        state_d     = (outer_clamp == '0 || inner_clamp == '0) ? DONE : RUN;
      end
      // abort wins over a same-cycle beat; the beat still counts as delivered downstream
      RUN: if (abort) begin
        state_d = IDLE;
        clr     = 1'b1;
      end else if (beat && out_last) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= IDLE;
      outer_cnt_q <= '0;
      inner_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      outer_cnt_q <= outer_cnt_d;
      inner_cnt_q <= inner_cnt_d;
    end
  loop_nest_counter #(.W(JW), .CW(ICW)) u_inner (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(beat),
    .limit(inner_cnt_q), .cnt(out_j), .tc(inner_tc)
  );
  // the outer level steps only when the inner level wraps on a delivered beat
  loop_nest_counter #(.W(IW), .CW(OCW)) u_outer (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(beat && inner_tc),
    .limit(outer_cnt_q), .cnt(out_i), .tc(outer_tc)
  );
  assign out_valid       = run;
  assign out_first_inner = run && out_j == '0;
  assign out_last_inner  = run && inner_tc;
  assign out_last        = out_last_inner && outer_tc;
  assign busy            = state_q != IDLE;
  assign done            = state_q == DONE;
endmodule

// File: tb/tb_loop_nest_sequencer.sv
// tb_loop_nest_sequencer: randomized and directed checks of loop_nest_sequencer against a beat-index model
module tb_loop_nest_sequencer;
  logic clk = 0, rst_n = 1, start = 0, abort = 0, out_ready = 0;
  logic [3:0] cfg_outer = 0, cfg_inner = 0;
  logic out_valid, out_first_inner, out_last_inner, out_last, busy, done;
  logic [2:0] out_i, out_j;
  int vectors = 0, errors = 0, cyc = 0;
  int ph = 0, mo = 0, mi = 0, mk = 0, nb = 0, nd = 0, li = 0, lj = 0, dcyc = 0;
  int s_cyc = 0, b0 = 0, d0 = 0;

  loop_nest_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_outer(cfg_outer), .cfg_inner(cfg_inner),
    .out_valid(out_valid), .out_ready(out_ready), .out_i(out_i), .out_j(out_j),
    .out_first_inner(out_first_inner), .out_last_inner(out_last_inner), .out_last(out_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int clamp8(input int v);
    return v > 8 ? 8 : v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // model: ph 0 idle, 1 scanning, 2 done pulse; mk is the linear index of the next beat
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ph <= 0;
      mk <= 0;
    end else case (ph)
      0: if (start) begin
        mo <= clamp8(int'(cfg_outer));
        mi <= clamp8(int'(cfg_inner));
        mk <= 0;
        ph <= (clamp8(int'(cfg_outer)) == 0 || clamp8(int'(cfg_inner)) == 0) ? 2 : 1;
      end
      1: begin
        if (out_ready) begin
          nb <= nb + 1;
          li <= mk / mi;
          lj <= mk % mi;
          mk <= mk + 1;
        end
        if (abort) ph <= 0;
        else if (out_ready && mk == mo * mi - 1) ph <= 2;
      end
      default: begin
        ph   <= 0;
        nd   <= nd + 1;
        dcyc <= cyc;
      end
    endcase

  always @(negedge clk) begin : cmp
    int ei, ej;
    ei = (ph == 1) ? mk / mi : 0;
    ej = (ph == 1) ? mk % mi : 0;
    chk("out_valid", 32'(out_valid), 32'(ph == 1));
    chk("busy", 32'(busy), 32'(ph != 0));
    chk("done", 32'(done), 32'(ph == 2));
    chk("out_i", 32'(out_i), ei);
    chk("out_j", 32'(out_j), ej);
    chk("first_inner", 32'(out_first_inner), 32'(ph == 1 && ej == 0));
    chk("last_inner", 32'(out_last_inner), 32'(ph == 1 && ej == mi - 1));
    chk("out_last", 32'(out_last), 32'(ph == 1 && mk == mo * mi - 1));
  end

  task automatic start_scan(input int o, input int in, input bit rdy);
    @(negedge clk);
    cfg_outer = o[3:0];
    cfg_inner = in[3:0];
    start = 1;
    abort = 0;
    out_ready = rdy;
    s_cyc = cyc;
    b0 = nb;
    d0 = nd;
  endtask

  // mode 0: ready always 1; mode 1: ready 1,0,0 repeating; mode 2: random ready
  task automatic wait_idle(input int mode, input bit noise);
    int n = 0;
    while (n < 3000) begin
      @(negedge clk);
      start = 0;
      abort = 0;
      if (ph == 0) break;
      n++;
      out_ready = mode == 0 ? 1'b1 : mode == 1 ? ((n - 1) % 3 == 0) : 1'($urandom % 2);
      if (noise) begin
        if ($urandom % 10 == 0) begin
          start = 1;
          cfg_outer = 4'($urandom);
          cfg_inner = 4'($urandom);
        end
        abort = ($urandom % 50 == 0);
      end
    end
    chk("scan_timeout", 32'(n < 3000), 1);
  endtask

  initial begin
    #1 rst_n = 0;
    repeat (2) @(negedge clk);
    chk("reset_valid", 32'(out_valid), 0);
    chk("reset_busy", 32'(busy), 0);
    rst_n = 1;
    start_scan(2, 3, 1);
    wait_idle(0, 0);
    chk("t1_beats", nb - b0, 6);
    chk("t1_last_i", li, 1);
    chk("t1_last_j", lj, 2);
    chk("t1_done_cyc", dcyc - s_cyc, 7);
    chk("t1_done_cnt", nd - d0, 1);
    start_scan(2, 3, 1);
    wait_idle(1, 0);
    chk("t2_beats", nb - b0, 6);
    chk("t2_last_j", lj, 2);
    chk("t2_done_cnt", nd - d0, 1);
    start_scan(0, 5, 1);
    wait_idle(0, 0);
    chk("t3_beats", nb - b0, 0);
    chk("t3_done_cyc", dcyc - s_cyc, 1);
    start_scan(8, 8, 1);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      start = 0;
      if (nb - b0 == 9) break;
    end
    abort = 1;
    @(negedge clk);
    abort = 0;
    chk("t4_busy_after_abort", 32'(busy), 0);
    chk("t4_beats", nb - b0, 10);
    chk("t4_last_i", li, 1);
    chk("t4_last_j", lj, 1);
    chk("t4_no_done", nd - d0, 0);
    start_scan(2, 2, 1);
    wait_idle(0, 0);
    chk("t4_restart_beats", nb - b0, 4);
    start_scan(15, 1, 1);
    wait_idle(0, 0);
    chk("t5_beats", nb - b0, 8);
    chk("t5_last_i", li, 7);
    chk("t5_last_j", lj, 0);
    start_scan(2, 3, 1);
    @(negedge clk);
    start = 1;
    cfg_outer = 7;
    cfg_inner = 7;
    wait_idle(0, 0);
    chk("t6_beats", nb - b0, 6);
    chk("t6_last_j", lj, 2);
    start_scan(4, 4, 1);
    repeat (3) begin
      @(negedge clk);
      start = 0;
    end
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("t7_valid", 32'(out_valid), 0);
    chk("t7_busy", 32'(busy), 0);
    chk("t7_done", 32'(done), 0);
    chk("t7_i", 32'(out_i), 0);
    chk("t7_j", 32'(out_j), 0);
    chk("t7_markers", 32'({out_first_inner, out_last_inner, out_last}), 0);
    @(negedge clk);
    rst_n = 1;
    repeat (3) @(negedge clk);
    chk("t7_no_done", nd - d0, 0);
    repeat (40) begin
      start_scan(int'($urandom % 12), int'($urandom % 12), 1'($urandom % 2));
      wait_idle(1 + int'($urandom % 2), 1);
    end
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
